hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
Sequences all writes to the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO ops from the execute stage and runs a multi-cycle multiplier or an iterative radix-2 divider. It raises `busy` so the pipeline stalls HI/LO consumers, then emits a one-cycle write_hilo_t-style pulse toward writeback and the HI/LO forwarding network. A pipeline flush aborts an in-flight op.

Parameters:
- MUL_LATENCY, 2, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 32, busy cycles for DIV/DIVU, one quotient bit per cycle (≥1; 32 for full-precision radix-2)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start  in  1  op issue strobe from execute, one cycle per op
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
- a  in  32  rs operand (dividend / multiplicand / MT source)
- b  in  32  rt operand (divisor / multiplier)
- flush  in  1  pipeline flush (exception/eret); cancels op
- busy  out  1  registered; 1 while MUL or DIV in progress
- valid_hi  out  1  write-HI pulse
- hi  out  32  HI write data
- valid_lo  out  1  write-LO pulse
- lo  out  32  LO write data

Behaviour:
- Reset (async): state=IDLE, counter=0, busy=0, valid_hi=valid_lo=0, hi=lo=0.
- FSM states: IDLE, MUL, DIV. All outputs are registered.
- IDLE, start=1, flush=0, accepted at edge ending cycle T:
  - MULT/MULTU: go to MUL, counter=MUL_LATENCY.
  - DIV/DIVU: go to DIV, counter=DIV_CYCLES, latch operands and signs.
  - MTHI: stay IDLE; at T+1 valid_hi=1, hi=a, valid_lo=0.
  - MTLO: stay IDLE; at T+1 valid_lo=1, lo=a, valid_hi=0.
  - op 6/7: ignored.
- MUL/DIV: counter decrements each cycle. The edge at which counter==1 returns to IDLE and registers the result.
  - busy=1 for cycles T+1..T+N (N = MUL_LATENCY or DIV_CYCLES).
  - At T+N+1: busy=0, valid_hi=valid_lo=1 for exactly one cycle.
- Outside pulse cycles, valid_hi/valid_lo=0; hi/lo hold their last values.
- start while busy=1 is ignored. Execute must stall on busy; the bench checks that no state change occurs.
- Back-to-back: start is accepted in the same cycle a completion pulse is visible, since state is IDLE.
- MUL results: full 64-bit product, hi=[63:32], lo=[31:0].
  - MULT: signed×signed.
  - MULTU: unsigned×unsigned.
- DIV results: lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign; magnitudes come from the unsigned core.
  - Divide by zero (either variant): hi=a, lo=0xFFFFFFFF for DIVU; signed result = natural core output with sign correction. Defined; no exception.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Flush:
  - Flush in MUL/DIV: return to IDLE next edge, busy=0 next cycle, no pulse.
  - Flush with start in IDLE: start ignored (including MTHI/MTLO).
  - Flush does not retract a pulse already visible on the outputs.
- Reset mid-op: immediate IDLE, outputs cleared, no pulse.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF at T -> busy T+1..T+2; at T+3 valid_hi=valid_lo=1, hi=0xFFFFFFFE, lo=0x00000001; T+4 valids=0.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 at T+3; second MULT issued at T+3 accepted.
- DIV a=0xFFFFFFF9(-7) b=2 -> busy T+1..T+32; at T+33 lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- MTHI a=0x12345678 -> T+1 valid_hi=1, hi=0x12345678, valid_lo=0, busy never 1; MTLO analogous.
- DIV started at T, flush at T+10 -> busy=0 at T+11, no valid pulse through T+40; start with flush same cycle -> no effect.
- Reset asserted at T+5 of DIV (asynchronously, mid-cycle) -> busy, valids, hi, lo=0 immediately; DIVU 0x80000000/0 after release -> hi=0x80000000, lo=0xFFFFFFFF.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write sequencer: multi-cycle multiply, iterative radix-2 divide and MTHI/MTLO,
// producing registered one-cycle write pulses toward writeback and the forwarding network.
module hilo_muldiv_ctrl #(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        valid_hi,
    output logic [31:0] hi,
    output logic        valid_lo,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MUL_LATENCY > DIV_CYCLES) ? MUL_LATENCY : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // opa/opb hold the multiplicand/multiplier, or the dividend shift register/divisor magnitude.
    logic [31:0]   opa_q, opa_d;
    logic [31:0]   opb_q, opb_d;
    logic [31:0]   rem_q, rem_d;
    logic          mul_signed_q, mul_signed_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
    logic          busy_q, busy_d;
    logic          valid_hi_q, valid_hi_d;
    logic          valid_lo_q, valid_lo_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic [63:0]   ext_a, ext_b, prod;
    logic [32:0]   rem_shift, rem_sub;
    logic          q_bit;
    logic [31:0]   rem_next, quo_next;
    logic          div_signed, a_neg, b_neg;

    // Product is only consumed on the completion edge; sign-extending to 64 bits
    // makes the low 64 bits of an unsigned multiply equal the signed product.
    always_comb begin
        ext_a = {{32{mul_signed_q & opa_q[31]}}, opa_q};
        ext_b = {{32{mul_signed_q & opb_q[31]}}, opb_q};
        prod  = ext_a * ext_b;
    end

    // One restoring-division step: a clear bit 32 after subtraction means no borrow.
    always_comb begin
        rem_shift = {rem_q, opa_q[31]};
        rem_sub   = rem_shift - {1'b0, opb_q};
        q_bit     = ~rem_sub[32];
        rem_next  = q_bit ? rem_sub[31:0] : rem_shift[31:0];
        quo_next  = {opa_q[30:0], q_bit};
    end

    always_comb begin
        div_signed = (op == OP_DIV);
        a_neg      = div_signed & a[31];
        b_neg      = div_signed & b[31];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        rem_d        = rem_q;
        mul_signed_d = mul_signed_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        valid_hi_d   = 1'b0;
        valid_lo_d   = 1'b0;
        hi_d         = hi_q;
        lo_d         = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d      = S_MUL;
                            cnt_d        = CW'(MUL_LATENCY);
                            opa_d        = a;
                            opb_d        = b;
                            mul_signed_d = (op == OP_MULT);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d   = S_DIV;
                            cnt_d     = CW'(DIV_CYCLES);
                            opa_d     = a_neg ? (32'd0 - a) : a;
                            opb_d     = b_neg ? (32'd0 - b) : b;
                            rem_d     = 32'd0;
                            neg_quo_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                        end
                        OP_MTHI: begin
                            valid_hi_d = 1'b1;
                            hi_d       = a;
                        end
                        OP_MTLO: begin
                            valid_lo_d = 1'b1;
                            lo_d       = a;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d    = S_IDLE;
                        valid_hi_d = 1'b1;
                        valid_lo_d = 1'b1;
                        hi_d       = prod[63:32];
                        lo_d       = prod[31:0];
                    end
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    opa_d = quo_next;
                    rem_d = rem_next;
                    if (cnt_q == CW'(1)) begin
                        state_d    = S_IDLE;
                        valid_hi_d = 1'b1;
                        valid_lo_d = 1'b1;
                        hi_d       = neg_rem_q ? (32'd0 - rem_next) : rem_next;
                        lo_d       = neg_quo_q ? (32'd0 - quo_next) : quo_next;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            rem_q        <= 32'd0;
            mul_signed_q <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            busy_q       <= 1'b0;
            valid_hi_q   <= 1'b0;
            valid_lo_q   <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            rem_q        <= rem_d;
            mul_signed_q <= mul_signed_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
            busy_q       <= busy_d;
            valid_hi_q   <= valid_hi_d;
            valid_lo_q   <= valid_lo_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign valid_hi = valid_hi_q;
    assign valid_lo = valid_lo_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: directed scenarios plus random op streams, every cycle
// compared against an arithmetic reference model with a result queue.
module tb_hilo_muldiv_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DIV_CYC = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        valid_hi;
  logic [31:0] hi;
  logic        valid_lo;
  logic [31:0] lo;

  hilo_muldiv_ctrl #(
    .MUL_LATENCY(MUL_LAT),
    .DIV_CYCLES (DIV_CYC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .busy    (busy),
    .valid_hi(valid_hi),
    .hi      (hi),
    .valid_lo(valid_lo),
    .lo      (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: {hi, lo} of each issued MUL/DIV, in issue order
  logic [63:0] exp_q[$];
  int          m_left;
  logic        m_busy, m_vhi, m_vlo;
  logic [31:0] m_hi, m_lo;
  int          n_checks;
  int          n_pass;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] mul_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic sgn);
    longint      sx, sy;
    logic [63:0] ux, uy;
    if (sgn) begin
      sx = longint'(signed'(x));
      sy = longint'(signed'(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  // returns {remainder, quotient}
  function automatic logic [63:0] div_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic sgn);
    logic [31:0] mx, my, qm, rm, q, r;
    logic        nx, ny;
    nx = sgn && x[31];
    ny = sgn && y[31];
    mx = nx ? -x : x;
    my = ny ? -y : y;
    if (my == 0) begin
      qm = 32'hFFFF_FFFF;
      rm = mx;
    end else begin
      qm = mx / my;
      rm = mx % my;
    end
    q = (nx != ny) ? -qm : qm;
    r = nx ? -rm : rm;
    return {r, q};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_left = 0;
    m_busy = 0;
    m_vhi  = 0;
    m_vlo  = 0;
    m_hi   = 0;
    m_lo   = 0;
  endtask

  task automatic model_step(input logic s, input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic f);
    logic [63:0] r;
    m_vhi = 0;
    m_vlo = 0;
    if (m_left > 0) begin
      if (f) begin
        m_left = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_empty", 1, 0);
          end else begin
            r = exp_q.pop_front();
            m_hi = r[63:32];
            m_lo = r[31:0];
            m_vhi = 1;
            m_vlo = 1;
          end
        end
      end
    end else if (s && !f) begin
      case (o)
        OP_MULT, OP_MULTU: begin
          exp_q.push_back(mul_model(x, y, o == OP_MULT));
          m_left = MUL_LAT;
        end
        OP_DIV, OP_DIVU: begin
          exp_q.push_back(div_model(x, y, o == OP_DIV));
          m_left = DIV_CYC;
        end
        OP_MTHI: begin
          m_hi = x;
          m_vhi = 1;
        end
        OP_MTLO: begin
          m_lo = x;
          m_vlo = 1;
        end
        default: ;
      endcase
    end
    m_busy = (m_left > 0);
  endtask

  // driver: present inputs for one cycle, advance model at the edge, compare after it
  task automatic tick(input logic s, input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic f);
    start = s;
    op    = o;
    a     = x;
    b     = y;
    flush = f;
    @(posedge clk);
    model_step(s, o, x, y, f);
    #1;
    check_eq("busy", busy, m_busy);
    check_eq("valid_hi", valid_hi, m_vhi);
    check_eq("valid_lo", valid_lo, m_vlo);
    check_eq("hi", hi, m_hi);
    check_eq("lo", lo, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 3'd0, $urandom, $urandom, 0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1;
    start = 0;
    op    = 0;
    a     = 0;
    b     = 0;
    flush = 0;
    model_reset();
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_vhi", valid_hi, 0);
    check_eq("rst_vlo", valid_lo, 0);
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    reset = 0;

    // MULTU max*max: pulse on the third cycle after issue
    tick(1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    idle(2);
    check_eq("plan_multu_v", {valid_hi, valid_lo}, 2'b11);
    check_eq("plan_multu_hi", hi, 32'hFFFF_FFFE);
    check_eq("plan_multu_lo", lo, 32'h0000_0001);
    idle(1);

    // MULT -3*5, then a second MULT issued in the pulse cycle
    tick(1, OP_MULT, 32'hFFFF_FFFD, 32'd5, 0);
    idle(2);
    check_eq("plan_mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("plan_mult_lo", lo, 32'hFFFF_FFF1);
    tick(1, OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    idle(3);

    // DIV -7/2 with starts attempted while busy
    tick(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    for (int i = 0; i < DIV_CYC; i++)
      tick(i % 5 == 0, OP_MTHI, $urandom, $urandom, 0);
    check_eq("plan_div_lo", lo, 32'hFFFF_FFFD);
    check_eq("plan_div_hi", hi, 32'hFFFF_FFFF);
    tick(1, OP_DIVU, 32'd100, 32'd7, 0);
    idle(DIV_CYC);
    check_eq("plan_divu_lo", lo, 32'd14);
    check_eq("plan_divu_hi", hi, 32'd2);
    tick(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(DIV_CYC);
    check_eq("plan_ovf_lo", lo, 32'h8000_0000);
    check_eq("plan_ovf_hi", hi, 32'd0);

    // MTHI / MTLO
    tick(1, OP_MTHI, 32'h1234_5678, 32'd0, 0);
    check_eq("plan_mthi", {busy, valid_hi, valid_lo, hi}, {3'b010, 32'h1234_5678});
    tick(1, OP_MTLO, 32'h9ABC_DEF0, 32'd0, 0);
    check_eq("plan_mtlo", {busy, valid_hi, valid_lo, lo}, {3'b001, 32'h9ABC_DEF0});
    idle(1);

    // flush mid-divide, then start+flush together
    tick(1, OP_DIV, 32'd1000, 32'd3, 0);
    idle(9);
    tick(0, 3'd0, 32'd0, 32'd0, 1);
    check_eq("plan_flush_busy", busy, 0);
    idle(30);
    tick(1, OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1);
    tick(1, OP_MULT, 32'd3, 32'd3, 1);
    idle(4);

    // asynchronous reset mid-divide
    tick(1, OP_DIVU, 32'hFFFF_0000, 32'd9, 0);
    idle(4);
    #3;
    reset = 1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_vhi", valid_hi, 0);
    check_eq("arst_vlo", valid_lo, 0);
    check_eq("arst_hi", hi, 0);
    check_eq("arst_lo", lo, 0);
    model_reset();
    #1;
    reset = 0;
    idle(3);
    tick(1, OP_DIVU, 32'h8000_0000, 32'd0, 0);
    idle(DIV_CYC);
    check_eq("plan_dz_hi", hi, 32'h8000_0000);
    check_eq("plan_dz_lo", lo, 32'hFFFF_FFFF);
    tick(1, OP_DIV, 32'hFFFF_FFF0, 32'd0, 0);
    idle(DIV_CYC + 1);

    // random op stream
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), rand_operand(),
           rand_operand(), $urandom_range(0, 39) == 0);
    idle(DIV_CYC + 2);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
